// File: rtl/board_scan_scheduler.sv
// Scans a PISO sensor chain, debounces frames and reports confirmed board changes via valid/ack.
// Optional debug LED port is enabled by defining SCAN_DEBUG_LED_EN.
module board_scan_scheduler #(
    parameter int CLK_DIV      = 64,
    parameter int NUM_BITS     = 32,
    parameter int SCAN_GAP     = 6000,
    parameter int STABLE_SCANS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sr_in,
    output logic        sr_clk,
    output logic        sr_load_n,
    input  logic        scan_req,
    output logic        scan_busy,
    output logic [31:0] board_state,
    output logic        change_valid,
    output logic [31:0] change_mask,
    input  logic        change_ack,
    output logic [15:0] scan_count
`ifdef SCAN_DEBUG_LED_EN
    ,
    output logic [15:0] led
`endif
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int SW = (STABLE_SCANS > 2) ? $clog2(STABLE_SCANS + 1) : 2;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(SCAN_GAP - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SCANS);
    localparam logic [5:0]    BITS_LAST  = 6'(NUM_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    logic [2:0]    state;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic          load_half;
    logic [5:0]    bit_idx;
    logic [31:0]   frame;
    logic [31:0]   last_frame;
    logic [SW-1:0] stable_cnt;
    logic          req_pend;

    logic          tick;
    logic          go_load;
    logic [SW-1:0] stable_nxt;
    logic          accept;
    logic          ack_take;
    logic [31:0]   diff;

    assign tick      = (div_cnt == DIV_LAST);
    assign scan_busy = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_COMMIT);
    assign diff      = frame ^ board_state;
    assign ack_take  = change_ack & change_valid;

    // A pending request (or a zero-length gap) sends COMMIT straight back to LOAD.
    always_comb begin
        go_load = 1'b0;
        case (state)
            ST_IDLE:   go_load = 1'b1;
            ST_COMMIT: go_load = req_pend | scan_req | (SCAN_GAP == 0);
            ST_GAP:    go_load = scan_req | (gap_cnt == GAP_LAST);
            default:   go_load = 1'b0;
        endcase
    end

    always_comb begin
        stable_nxt = SW'(1);
        if (frame == last_frame) begin
            stable_nxt = (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + SW'(1);
        end
        accept = (state == ST_COMMIT) && (stable_nxt == STABLE_MAX) && (frame != board_state);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            load_half    <= 1'b0;
            bit_idx      <= '0;
            frame        <= '0;
            last_frame   <= '0;
            stable_cnt   <= '0;
            req_pend     <= 1'b0;
            sr_clk       <= 1'b0;
            sr_load_n    <= 1'b1;
            board_state  <= '0;
            change_valid <= 1'b0;
            change_mask  <= '0;
            scan_count   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (scan_busy && scan_req) begin
                req_pend <= 1'b1;
            end

            case (state)
                ST_LOAD: begin
                    if (tick) begin
                        if (load_half) begin
                            state     <= ST_SHIFT;
                            sr_load_n <= 1'b1;
                            bit_idx   <= '0;
                            div_cnt   <= '0;
                        end else begin
                            load_half <= 1'b1;
                        end
                    end
                end
                // Sample on the low-phase tick so bit 0 is taken before the first rising edge.
                ST_SHIFT: begin
                    if (tick) begin
                        if (!sr_clk) begin
                            frame[bit_idx[4:0]] <= sr_in;
                            bit_idx             <= bit_idx + 6'd1;
                            sr_clk              <= 1'b1;
                        end else begin
                            sr_clk <= 1'b0;
                            if (bit_idx == BITS_LAST) begin
                                state   <= ST_COMMIT;
                                div_cnt <= '0;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    scan_count <= scan_count + 16'd1;
                    last_frame <= frame;
                    stable_cnt <= stable_nxt;
                    req_pend   <= 1'b0;
                    if (accept) begin
                        board_state <= frame;
                    end
                    if (!go_load) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                end
            endcase

            if (go_load) begin
                state     <= ST_LOAD;
                sr_load_n <= 1'b0;
                sr_clk    <= 1'b0;
                load_half <= 1'b0;
                div_cnt   <= '0;
                frame     <= '0;
            end

            // A fresh diff takes priority over a same-cycle ack.
            if (accept) begin
                change_valid <= 1'b1;
                change_mask  <= ack_take ? diff : (change_mask | diff);
            end else if (ack_take) begin
                change_valid <= 1'b0;
                change_mask  <= '0;
            end
        end
    end

`ifdef SCAN_DEBUG_LED_EN
    assign led = {sr_clk, ~sr_load_n, sr_in, state, stable_cnt[1:0], board_state[7:0]};
`endif

endmodule

// File: tb/tb_board_scan_scheduler.sv
// Directed and randomized bench for board_scan_scheduler with a 74HC165-style chain model.
module tb_board_scan_scheduler;

    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sr_in;
    logic        sr_clk;
    logic        sr_load_n;
    logic        scan_req;
    logic        scan_busy;
    logic [31:0] board_state;
    logic        change_valid;
    logic [31:0] change_mask;
    logic        change_ack;
    logic [15:0] scan_count;

    logic [31:0] chain = 32'd0;
    logic [31:0] sh = 32'd0;
    logic [31:0] scan_frame = 32'd0;
    logic        prev_sr = 1'b0;
    logic        prev_ld = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] hist[$];
    logic [31:0] m_board;
    logic [31:0] m_mask;
    logic        m_valid;
    logic [15:0] m_count;

    board_scan_scheduler #(
        .CLK_DIV(4), .NUM_BITS(32), .SCAN_GAP(20), .STABLE_SCANS(STABLE)
    ) dut (
        .clk(clk), .reset(reset), .sr_in(sr_in), .sr_clk(sr_clk), .sr_load_n(sr_load_n),
        .scan_req(scan_req), .scan_busy(scan_busy), .board_state(board_state),
        .change_valid(change_valid), .change_mask(change_mask), .change_ack(change_ack),
        .scan_count(scan_count)
    );

    always #5 clk = ~clk;

    // Chain: parallel load while load_n low, shift toward the output on each sr_clk rise.
    assign sr_in = sh[0];
    always @(negedge clk) begin
        if (!sr_load_n) begin
            sh = chain;
        end else begin
            if (!prev_ld) scan_frame = sh;
            if (sr_clk && !prev_sr) sh = {1'b0, sh[31:1]};
        end
        prev_ld = sr_load_n;
        prev_sr = sr_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_board = 32'd0;
        m_mask  = 32'd0;
        m_valid = 1'b0;
        m_count = 16'd0;
    endtask

    // A frame is accepted once the last STABLE frames since reset are all identical.
    task automatic model_commit(input logic [31:0] f, input bit ack_same);
        bit          stable;
        logic [31:0] d;
        hist.push_back(f);
        if (hist.size() > STABLE) void'(hist.pop_front());
        stable = (hist.size() == STABLE);
        foreach (hist[k]) if (hist[k] != f) stable = 1'b0;
        m_count = m_count + 16'd1;
        if (stable && f != m_board) begin
            d       = f ^ m_board;
            m_board = f;
            m_mask  = (ack_same && m_valid) ? d : (m_mask | d);
            m_valid = 1'b1;
        end else if (ack_same && m_valid) begin
            m_valid = 1'b0;
            m_mask  = 32'd0;
        end
    endtask

    task automatic commit_check(input bit ack_same);
        model_commit(scan_frame, ack_same);
        chk("board_state", board_state, m_board);
        chk("change_valid", 32'(change_valid), 32'(m_valid));
        chk("change_mask", change_mask, m_mask);
        chk("scan_count", 32'(scan_count), 32'(m_count));
    endtask

    task automatic wait_scan();
        logic [15:0] prev;
        int          n;
        prev = scan_count;
        n = 0;
        while (scan_count === prev && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_done", 32'(scan_count !== prev), 32'd1);
        commit_check(1'b0);
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        while (sr_load_n === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("load_seen", 32'(sr_load_n), 32'd0);
    endtask

    task automatic do_ack();
        change_ack = 1'b1;
        @(negedge clk);
        change_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_mask  = 32'd0;
        end
        chk("ack_valid", 32'(change_valid), 32'(m_valid));
        chk("ack_mask", change_mask, m_mask);
    endtask

    task automatic measure_scan();
        logic [15:0] prev;
        int          n, load_low, busy, rises, per_bad, clk_out, busy_bad, last_rise;
        logic        p;
        prev = scan_count;
        n = 0; load_low = 0; busy = 0; rises = 0; per_bad = 0;
        clk_out = 0; busy_bad = 0; last_rise = -1;
        p = sr_clk;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (scan_count !== prev) break;
            if (!sr_load_n) load_low++;
            if (scan_busy) busy++;
            if (!sr_load_n && !scan_busy) busy_bad++;
            if (sr_clk && (!scan_busy || !sr_load_n)) clk_out++;
            if (sr_clk && !p) begin
                rises++;
                if (last_rise >= 0 && (n - last_rise) != 8) per_bad++;
                last_rise = n;
            end
            p = sr_clk;
        end
        chk("scan_done", 32'(scan_count !== prev), 32'd1);
        chk("load_low_clocks", 32'(load_low), 32'd8);
        chk("sr_clk_rises", 32'(rises), 32'd32);
        chk("sr_clk_period_errs", 32'(per_bad), 32'd0);
        chk("sr_clk_outside_shift", 32'(clk_out), 32'd0);
        chk("busy_clocks", 32'(busy), 32'd265);
        chk("busy_during_load", 32'(busy_bad), 32'd0);
        chk("busy_after_commit", 32'(scan_busy), 32'd0);
        commit_check(1'b0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_sr_clk"}, 32'(sr_clk), 32'd0);
        chk({tag, "_sr_load_n"}, 32'(sr_load_n), 32'd1);
        chk({tag, "_busy"}, 32'(scan_busy), 32'd0);
        chk({tag, "_board"}, board_state, 32'd0);
        chk({tag, "_valid"}, 32'(change_valid), 32'd0);
        chk({tag, "_mask"}, change_mask, 32'd0);
        chk({tag, "_count"}, 32'(scan_count), 32'd0);
    endtask

    initial begin
        int          n;
        int unsigned r;

        reset = 1'b1;
        scan_req = 1'b0;
        change_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_checks("rst");

        // Static board is accepted on the second identical scan.
        chain = 32'hA5A50F0F;
        reset = 1'b0;
        @(negedge clk);
        chk("load_after_reset", 32'(sr_load_n), 32'd0);
        wait_scan();
        measure_scan();
        do_ack();

        // One-scan glitch on bit 3 must be filtered out.
        chain = 32'hA5A50F07;
        wait_scan();
        chain = 32'hA5A50F0F;
        wait_scan();
        wait_scan();

        // Accumulating mask before ack.
        chain = 32'hA5A50F0E;
        wait_scan();
        wait_scan();
        chain = 32'hA5A50F0C;
        wait_scan();
        wait_scan();
        do_ack();

        // Ack in the same cycle as a new diff: the new diff alone remains.
        chain = 32'hA5A50F0D;
        wait_scan();
        wait_scan();
        chain = 32'hA5A50F0F;
        wait_scan();
        wait_load();
        repeat (264) @(negedge clk);
        chk("commit_busy", 32'(scan_busy), 32'd1);
        change_ack = 1'b1;
        @(negedge clk);
        change_ack = 1'b0;
        commit_check(1'b1);

        // Request 5 clocks into the gap starts LOAD on the next cycle.
        repeat (5) @(negedge clk);
        chk("gap_before_req", 32'(sr_load_n), 32'd1);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        chk("req_in_gap_load", 32'(sr_load_n), 32'd0);
        wait_scan();

        // Two requests during SHIFT collapse into one zero-gap rescan.
        wait_load();
        repeat (50) @(negedge clk);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        repeat (40) @(negedge clk);
        scan_req = 1'b1;
        @(negedge clk);
        scan_req = 1'b0;
        wait_scan();
        chk("zero_gap_load", 32'(sr_load_n), 32'd0);
        wait_scan();
        n = 0;
        while (sr_load_n === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("normal_gap_len", 32'(n), 32'd20);
        wait_scan();

        // Reset part-way through SHIFT, then a clean full capture.
        wait_load();
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            if (sr_clk && !prev_sr) n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset_checks("midscan_rst");
        chain = 32'h3C5A9617;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst2_load", 32'(sr_load_n), 32'd0);
        chk("rst2_busy", 32'(scan_busy), 32'd1);
        wait_scan();
        wait_scan();

        // Scan counter wraps.
        force dut.scan_count = 16'hFFFF;
        @(negedge clk);
        release dut.scan_count;
        m_count = 16'hFFFF;
        wait_scan();

        // Randomized board activity, acks and gap requests.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) chain = $urandom;
            else if (r == 1) chain = chain ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) do_ack();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
                scan_req = 1'b1;
                @(negedge clk);
                scan_req = 1'b0;
            end
            wait_scan();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
